// File: rtl/solomon_cen_gen_if.sv
// Configuration bus of the clock-enable generator: write strobe, target channel,
// register select (NUM/DEN) and write data.
interface solomon_cen_gen_if #(
  parameter int W = 8
);
  logic         CFG_WE;
  logic [2:0]   CFG_CH;
  logic         CFG_SEL;
  logic [W-1:0] CFG_D;

  modport master (output CFG_WE, CFG_CH, CFG_SEL, CFG_D);
  modport slave  (input  CFG_WE, CFG_CH, CFG_SEL, CFG_D);
endinterface

// File: rtl/solomon_cen_gen.sv
// Fractional clock-enable generator: NCH Bresenham-paced CEN pulses at MCLK*NUM/DEN,
// a toggle output per channel and a free-running binary prescaler, all on MCLK.
module solomon_cen_gen #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int DIVW = 5
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic              PAUSE,
  input  logic              SYNC,
  solomon_cen_gen_if.slave  cfg,
  output logic [NCH-1:0]    CEN,
  output logic [NCH-1:0]    TGL,
  output logic [DIVW-1:0]   DIV
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] acc;
    logic         cen;
    logic         tgl;
    logic [W:0]   sum;
    logic         wr_hit;

    // One spare bit keeps acc + num exact since acc < DEN and NUM < DEN.
    assign sum    = {1'b0, acc} + {1'b0, num};
    assign wr_hit = cfg.CFG_WE && (cfg.CFG_CH == 3'(c));
    assign CEN[c] = cen;
    assign TGL[c] = tgl;

    always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        num <= W'(1);
        den <= W'(32'd2 << c);
        acc <= '0;
        cen <= 1'b0;
        tgl <= 1'b0;
      end else begin
        if (SYNC) begin
          acc <= '0;
          cen <= 1'b0;
          tgl <= 1'b0;
        end else if (PAUSE) begin
          cen <= 1'b0;
        end else if (den == '0) begin
          acc <= '0;
          cen <= 1'b0;
        end else if (num == '0) begin
          cen <= 1'b0;
        end else if (num >= den) begin
          acc <= '0;
          cen <= 1'b1;
          tgl <= ~tgl;
        end else if (sum >= {1'b0, den}) begin
          acc <= W'(sum - {1'b0, den});
          cen <= 1'b1;
          tgl <= ~tgl;
        end else begin
          acc <= sum[W-1:0];
          cen <= 1'b0;
        end

        // Writes land after the arithmetic; a new DEN restarts the phase so acc < DEN holds.
        if (wr_hit) begin
          if (cfg.CFG_SEL) begin
            den <= cfg.CFG_D;
            acc <= '0;
          end else begin
            num <= cfg.CFG_D;
          end
        end
      end
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DIV <= '0;
    end else if (SYNC) begin
      DIV <= '0;
    end else if (!PAUSE) begin
      DIV <= DIV + DIVW'(1);
    end
  end

endmodule
